// File: rtl/apb_master_bridge_if.sv
// Request/response and APB signal bundle for apb_master_bridge.
// The master modport is the bridge's view; slave is the surrounding requester and APB target.
interface apb_master_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PSELx;
    logic              PENABLE;
    logic              PWRITE;
    logic              PREADY;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               PADDR, PWDATA, PSELx, PENABLE, PWRITE
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               PADDR, PWDATA, PSELx, PENABLE, PWRITE
    );
endinterface

// File: rtl/apb_master_bridge.sv
// Valid/ready request port to APB SETUP/ACCESS transfers with a one-cycle response pulse.
// Optional ACCESS wait-state timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_bridge #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    apb_master_bridge_if.master  bus
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t state_q, state_d;
    logic   accept;
    logic   done;
    logic   abort;

    generate
        if (TO_W < $clog2(TIMEOUT_CYCLES + 1)) begin : g_to_w_chk
            $error("TO_W too narrow for TIMEOUT_CYCLES");
        end
    endgenerate

`ifdef APB_MASTER_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;
    logic            rsp_err_q;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
`endif

    // Bus controls decode straight from state so an async reset drops PSELx/PENABLE at once.
    always_comb begin
        state_d       = state_q;
        accept        = 1'b0;
        done          = 1'b0;
        abort         = 1'b0;
        bus.req_ready = 1'b0;
        bus.PSELx     = 1'b0;
        bus.PENABLE   = 1'b0;
        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    accept  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                bus.PSELx = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                bus.PSELx   = 1'b1;
                bus.PENABLE = 1'b1;
                if (bus.PREADY) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
`ifdef APB_MASTER_TIMEOUT_EN
                else if (to_cnt == TO_LAST) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q       <= IDLE;
            bus.PADDR     <= {ADDR_W{1'b0}};
            bus.PWDATA    <= {DATA_W{1'b0}};
            bus.PWRITE    <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= {DATA_W{1'b0}};
        end else begin
            state_q       <= state_d;
            bus.rsp_valid <= done | abort;
            if (accept) begin
                bus.PADDR  <= bus.req_addr;
                bus.PWDATA <= bus.req_wdata;
                bus.PWRITE <= bus.req_write;
            end
            if (done) begin
                bus.rsp_rdata <= bus.PWRITE ? {DATA_W{1'b0}} : bus.PRDATA;
            end else if (abort) begin
                bus.rsp_rdata <= {DATA_W{1'b0}};
            end
        end
    end

`ifdef APB_MASTER_TIMEOUT_EN
    // Counter is cleared in SETUP so it starts at zero on the first ACCESS cycle.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            to_cnt    <= {TO_W{1'b0}};
            rsp_err_q <= 1'b0;
        end else begin
            if (state_q == SETUP) begin
                to_cnt <= {TO_W{1'b0}};
            end else if (state_q == ACCESS && !bus.PREADY) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (done | abort) begin
                rsp_err_q <= abort;
            end
        end
    end

    assign bus.rsp_err = rsp_err_q;
`else
    assign bus.rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: transfers, wait states, back-to-back, reset, timeout.
module tb_apb_master_bridge;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    apb_master_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    apb_master_bridge #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4), .TO_W(8)
    ) dut (
        .PCLK    (clk),
        .PRESETn (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = data;
    endtask

    initial begin
        bit seen_rsp;
        n_tests = 0;
        n_fail  = 0;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.PRDATA    = '0;
        bus.PREADY    = 1'b1;
        tick();
        tick();
        check("rst_psel", bus.PSELx, 1'b0);
        check("rst_penable", bus.PENABLE, 1'b0);
        check("rst_paddr", bus.PADDR, 32'h0);
        check("rst_pwdata", bus.PWDATA, 32'h0);
        check("rst_pwrite", bus.PWRITE, 1'b0);
        check("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        check("rst_rsp_err", bus.rsp_err, 1'b0);
        check("rst_req_ready", bus.req_ready, 1'b1);
        rst_n = 1'b1;
        tick();
        // PREADY high while idle must not start anything
        check("idle_pready_psel", bus.PSELx, 1'b0);
        check("idle_pready_ready", bus.req_ready, 1'b1);

        // 1: zero-wait write, PREADY already high during SETUP
        request(1'b1, 32'h0000_0004, 32'h0000_0041);
        tick();
        bus.req_valid = 1'b0;
        check("wr_setup_psel", bus.PSELx, 1'b1);
        check("wr_setup_penable", bus.PENABLE, 1'b0);
        check("wr_setup_ready", bus.req_ready, 1'b0);
        check("wr_setup_paddr", bus.PADDR, 32'h4);
        check("wr_setup_pwrite", bus.PWRITE, 1'b1);
        check("wr_setup_pwdata", bus.PWDATA, 32'h41);
        check("wr_setup_rsp", bus.rsp_valid, 1'b0);
        tick();
        check("wr_access_penable", bus.PENABLE, 1'b1);
        check("wr_access_psel", bus.PSELx, 1'b1);
        check("wr_access_rsp", bus.rsp_valid, 1'b0);
        tick();
        check("wr_rsp_valid", bus.rsp_valid, 1'b1);
        check("wr_rsp_err", bus.rsp_err, 1'b0);
        check("wr_rsp_rdata", bus.rsp_rdata, 32'h0);
        check("wr_idle_psel", bus.PSELx, 1'b0);
        check("wr_idle_ready", bus.req_ready, 1'b1);
        tick();
        check("wr_rsp_pulse", bus.rsp_valid, 1'b0);

        // 2: read with two wait states; PRDATA changes only in the final ACCESS cycle
        bus.PREADY = 1'b0;
        bus.PRDATA = 32'h0000_0011;
        request(1'b0, 32'h0000_0008, 32'hDEAD_BEEF);
        tick();
        bus.req_valid = 1'b0;
        bus.req_addr  = 32'hFFFF_FFFF;
        check("rd_setup_pwrite", bus.PWRITE, 1'b0);
        tick();
        check("rd_acc1_penable", bus.PENABLE, 1'b1);
        check("rd_acc1_paddr", bus.PADDR, 32'h8);
        tick();
        check("rd_acc2_penable", bus.PENABLE, 1'b1);
        check("rd_acc2_paddr", bus.PADDR, 32'h8);
        check("rd_acc2_rsp", bus.rsp_valid, 1'b0);
        tick();
        bus.PREADY = 1'b1;
        bus.PRDATA = 32'h0000_00A5;
        check("rd_acc3_penable", bus.PENABLE, 1'b1);
        check("rd_acc3_paddr", bus.PADDR, 32'h8);
        tick();
        check("rd_rsp_valid", bus.rsp_valid, 1'b1);
        check("rd_rsp_rdata", bus.rsp_rdata, 32'hA5);
        check("rd_rsp_err", bus.rsp_err, 1'b0);
        check("rd_idle_penable", bus.PENABLE, 1'b0);
        bus.PRDATA = 32'h0000_0077;
        tick();
        check("rd_rdata_hold", bus.rsp_rdata, 32'hA5);
        check("rd_paddr_hold", bus.PADDR, 32'h8);

        // 3: back-to-back writes with req_valid held
        request(1'b1, 32'h0000_0010, 32'h0000_1111);
        tick();
        tick();
        tick();
        check("b2b_rsp1", bus.rsp_valid, 1'b1);
        check("b2b_gap_psel", bus.PSELx, 1'b0);
        check("b2b_gap_ready", bus.req_ready, 1'b1);
        check("b2b_gap_paddr", bus.PADDR, 32'h10);
        request(1'b1, 32'h0000_0014, 32'h0000_2222);
        tick();
        bus.req_valid = 1'b0;
        check("b2b_setup2_psel", bus.PSELx, 1'b1);
        check("b2b_setup2_paddr", bus.PADDR, 32'h14);
        check("b2b_setup2_pwdata", bus.PWDATA, 32'h2222);
        tick();
        tick();
        check("b2b_rsp2", bus.rsp_valid, 1'b1);
        tick();

        // 4: async reset in ACCESS
        bus.PREADY = 1'b0;
        request(1'b0, 32'h0000_0020, 32'h0);
        tick();
        bus.req_valid = 1'b0;
        tick();
        check("rstacc_penable_pre", bus.PENABLE, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstacc_psel", bus.PSELx, 1'b0);
        check("rstacc_penable", bus.PENABLE, 1'b0);
        check("rstacc_paddr", bus.PADDR, 32'h0);
        bus.PREADY = 1'b1;
        tick();
        check("rstacc_rsp", bus.rsp_valid, 1'b0);
        rst_n = 1'b1;
        tick();
        check("rstacc_rsp_after", bus.rsp_valid, 1'b0);
        check("rstacc_ready", bus.req_ready, 1'b1);
        check("rstacc_psel_after", bus.PSELx, 1'b0);

        // 5: PREADY held low
        bus.PREADY = 1'b0;
        bus.PRDATA = 32'h0000_5A5A;
        request(1'b0, 32'h0000_0030, 32'h0);
        tick();
        bus.req_valid = 1'b0;
        tick();
`ifdef APB_MASTER_TIMEOUT_EN
        tick();
        tick();
        tick();
        check("to_acc4_penable", bus.PENABLE, 1'b1);
        check("to_acc4_rsp", bus.rsp_valid, 1'b0);
        tick();
        check("to_rsp_valid", bus.rsp_valid, 1'b1);
        check("to_rsp_err", bus.rsp_err, 1'b1);
        check("to_rsp_rdata", bus.rsp_rdata, 32'h0);
        check("to_psel", bus.PSELx, 1'b0);
        tick();
        // PREADY rising on the limit cycle completes normally
        request(1'b0, 32'h0000_0034, 32'h0);
        tick();
        bus.req_valid = 1'b0;
        tick();
        tick();
        tick();
        tick();
        bus.PREADY = 1'b1;
        tick();
        check("tolim_rsp_valid", bus.rsp_valid, 1'b1);
        check("tolim_rsp_err", bus.rsp_err, 1'b0);
        check("tolim_rsp_rdata", bus.rsp_rdata, 32'h5A5A);
        tick();
`else
        seen_rsp = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.rsp_valid) seen_rsp = 1'b1;
            tick();
        end
        check("wait_penable", bus.PENABLE, 1'b1);
        check("wait_no_rsp", seen_rsp, 1'b0);
        bus.PREADY = 1'b1;
        tick();
        check("wait_rsp_valid", bus.rsp_valid, 1'b1);
        check("wait_rsp_err", bus.rsp_err, 1'b0);
        check("wait_rsp_rdata", bus.rsp_rdata, 32'h5A5A);
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
